// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// datapath width, reset fetch address and the NOP encoding.
package fetch_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_slot.sv
// IF/ID slot register: clear wins over load, and with neither asserted the
// slot holds its contents.
module fetch_slot
    import fetch_pkg::*;
#(
    parameter int unsigned WORD_W = fetch_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [WORD_W-1:0] i_pc,
    input  logic [WORD_W-1:0] i_instr,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_pc,
    output logic [WORD_W-1:0] o_instr
);

    logic              r_valid;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_instr;

    // Clearing only drops valid; pc/instr keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= WORD_W'(NOP_INSTR);
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding instruction fetch: PC register, request FSM and the
// IF/ID slot. Redirects overwrite the PC and squash in-flight data.
module pc_fetch_unit #(
    parameter int unsigned        WORD_W   = fetch_pkg::WORD_W,
    parameter logic [WORD_W-1:0]  RESET_PC = WORD_W'(fetch_pkg::RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_instr,
    input  logic              if_ready
);

    import fetch_pkg::*;

    localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

    fetch_state_e      r_state;
    fetch_state_e      w_state_d;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_d;
    logic [WORD_W-1:0] r_req_pc;
    logic [WORD_W-1:0] w_req_pc_d;
    logic [WORD_W-1:0] w_redirect_pc;
    logic              w_req;
    logic              w_accept;
    logic              w_load;
    logic              w_clear;
    logic              unused_redirect_lsb;

    assign w_redirect_pc       = {redirect_pc[WORD_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Gated by rst_n so no request is visible while reset is held.
    assign w_req    = rst_n && (r_state == S_REQ) && (!if_valid || if_ready);
    assign w_accept = w_req && imem_gnt;

    always_comb begin
        w_state_d  = r_state;
        w_pc_d     = r_pc;
        w_req_pc_d = r_req_pc;
        w_load     = 1'b0;

        unique case (r_state)
            S_REQ: begin
                if (redirect_valid) begin
                    // A grant taken alongside a redirect is wrong-path.
                    if (w_accept) begin
                        w_state_d = S_DROP;
                    end
                end else if (w_accept) begin
                    w_req_pc_d = r_pc;
                    w_pc_d     = r_pc + PC_STEP;
                    w_state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    w_load    = 1'b1;
                    w_state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    w_state_d = S_REQ;
                end
            end
            default: begin
                w_state_d = S_REQ;
            end
        endcase

        if (redirect_valid) begin
            w_pc_d = w_redirect_pc;
        end
    end

    assign w_clear = redirect_valid || (if_valid && if_ready && !w_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            r_state  <= w_state_d;
            r_pc     <= w_pc_d;
            r_req_pc <= w_req_pc_d;
        end
    end

    fetch_slot #(
        .WORD_W (WORD_W)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_pc    (r_req_pc),
        .i_instr (imem_rdata),
        .o_valid (if_valid),
        .o_pc    (if_pc),
        .o_instr (if_instr)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_pc;

endmodule
